// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Data-memory request/acknowledge bus between the memory stage and the
// data memory.
//
// Signals
//   dmem_req    stage -> mem  access request, held until acknowledged
//   dmem_we     stage -> mem  1 = store, 0 = load
//   dmem_addr   stage -> mem  byte address (passed through unaligned)
//   dmem_wdata  stage -> mem  store data
//   dmem_rdata  mem -> stage  load data, valid while dmem_ack is high
//   dmem_ack    mem -> stage  one-cycle completion pulse
//
// Modports
//   master  memory-stage side (drives request fields)
//   slave   memory side (drives rdata/ack)
// -----------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int DBITS = 32
);
  logic             dmem_req;
  logic             dmem_we;
  logic [DBITS-1:0] dmem_addr;
  logic [DBITS-1:0] dmem_wdata;
  logic [DBITS-1:0] dmem_rdata;
  logic             dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory stage plus the MEM/WB pipeline register. Consumes the EX/MEM register
// outputs (*_m), performs data-memory loads/stores over a req/ack bus, stalls
// upstream while an access is outstanding, selects the writeback value
// (PC+4 for jal, load data, or ALU result) and presents registered MEM/WB
// signals (*_w) to the register file.
//
// Parameters
//   DBITS           data/address width
//   REGNOBITS       destination register index width
//   TIMEOUT_CYCLES  WAIT cycles allowed before an access is aborted
//                   (only meaningful with DMEM_TIMEOUT_EN)
//
// Ports
//   clk               clock, all state updates on posedge
//   reset             synchronous, active-high
//   memtoReg_m        load instruction
//   memWrite_m        store instruction
//   jal_m             jal, writeback PC+4
//   regWrite_m        instruction writes the register file
//   destReg_m         destination register
//   incrementedPC_m   PC+4
//   aluOut_m          ALU result / memory address
//   sr2Out_m          store data
//   stall             upstream holds EX/MEM while high (combinational)
//   dmem              data-memory bus (master side)
//   regWrite_w        MEM/WB write enable
//   destReg_w         MEM/WB destination
//   wbData_w          MEM/WB writeback value
//   mem_err           sticky access-timeout flag
//
// Configuration macro
//   DMEM_TIMEOUT_EN   when defined, an access that sees no ack within
//                     TIMEOUT_CYCLES WAIT cycles is aborted: the load value
//                     becomes 0 and mem_err is set until reset. When
//                     undefined, WAIT waits indefinitely and mem_err is 0.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DBITS          = 32,
  parameter int REGNOBITS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memtoReg_m,
  input  logic                 memWrite_m,
  input  logic                 jal_m,
  input  logic                 regWrite_m,
  input  logic [REGNOBITS-1:0] destReg_m,
  input  logic [DBITS-1:0]     incrementedPC_m,
  input  logic [DBITS-1:0]     aluOut_m,
  input  logic [DBITS-1:0]     sr2Out_m,
  output logic                 stall,
  mem_wb_stage_if.master       dmem,
  output logic                 regWrite_w,
  output logic [REGNOBITS-1:0] destReg_w,
  output logic [DBITS-1:0]     wbData_w,
  output logic                 mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e               state_q;
  logic                 req_q;
  logic                 we_q;
  logic [DBITS-1:0]     addr_q;
  logic [DBITS-1:0]     wdata_q;
  logic [DBITS-1:0]     rdata_q;

  logic                 reg_write_q;
  logic [REGNOBITS-1:0] dest_reg_q;
  logic [DBITS-1:0]     wb_data_q;

  logic                 reg_write_d;
  logic [REGNOBITS-1:0] dest_reg_d;
  logic [DBITS-1:0]     wb_data_d;

  logic                 mem_op_s;
  logic                 timeout_s;

  assign mem_op_s = memtoReg_m | memWrite_m;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wait_cnt_q;
  logic          mem_err_q;

  // Last permitted WAIT cycle: the counter started at 0 on entry to WAIT.
  assign timeout_s = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + CW'(1);
      if (!dmem.dmem_ack && timeout_s) begin
        mem_err_q <= 1'b1;
      end
    end else begin
      // Anywhere outside WAIT the counter sits at 0, so every entry
      // into WAIT starts a fresh count.
      wait_cnt_q <= '0;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Stall and MEM/WB next-value selection for the current FSM state.
  always_comb begin
    stall       = 1'b0;
    reg_write_d = 1'b0;
    dest_reg_d  = '0;
    wb_data_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          // Access about to start: hold upstream, push a bubble.
          stall = 1'b1;
        end else begin
          reg_write_d = regWrite_m;
          dest_reg_d  = destReg_m;
          wb_data_d   = jal_m ? incrementedPC_m : aluOut_m;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
      end
      S_DONE: begin
        // The stalled instruction is still in EX/MEM; retire it now.
        // Its memOp must not restart an access.
        reg_write_d = regWrite_m;
        dest_reg_d  = destReg_m;
        if (jal_m) begin
          wb_data_d = incrementedPC_m;
        end else if (memtoReg_m) begin
          wb_data_d = rdata_q;
        end else begin
          wb_data_d = aluOut_m;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Access FSM, bus request registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      reg_write_q <= 1'b0;
      dest_reg_q  <= '0;
      wb_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      dest_reg_q  <= dest_reg_d;
      wb_data_q   <= wb_data_d;
      case (state_q)
        S_IDLE: begin
          if (mem_op_s) begin
            req_q   <= 1'b1;
            we_q    <= memWrite_m;
            addr_q  <= aluOut_m;
            wdata_q <= sr2Out_m;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            req_q   <= 1'b0;
            rdata_q <= dmem.dmem_rdata;
            state_q <= S_DONE;
          end else if (timeout_s) begin
            // Abandon the access; a load then writes back zero.
            req_q   <= 1'b0;
            rdata_q <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign regWrite_w = reg_write_q;
  assign destReg_w  = dest_reg_q;
  assign wbData_w   = wb_data_q;

endmodule
